// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap/interrupt controller.
// Optional build macro used by trap_ctrl: TRAP_CTRL_IRQ_SYNC_EN.
package trap_pkg;

   typedef enum logic [1:0] {
      USER   = 2'd0,
      ISSUE  = 2'd1,
      KERNEL = 2'd2,
      FAULT  = 2'd3
   } trap_state_e;

   localparam int          CAUSE_W      = 5;
   localparam int          IDX_W        = 4;
   localparam logic [4:0]  CAUSE_XADR   = 5'h0F;
   localparam logic [31:0] VEC_IRQ_DEF  = 32'h8000_0004;
   localparam logic [31:0] VEC_XADR_DEF = 32'h8000_0008;

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder over the eligible IRQ lines.
// Zero latency; no flow control.
module irq_prio_enc
   import trap_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     i_req,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   // Walk downward so the lowest set bit is the last one written.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt controller: latches IRQ edges and illegal-instruction traps, redirects the PC
// with a valid/ack handshake, saves EPC/cause. Build macro TRAP_CTRL_IRQ_SYNC_EN adds an irq_in synchronizer.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int                NUM_IRQ  = 4,
   parameter int                PC_W     = 32,
   parameter logic [PC_W-1:0]   VEC_IRQ  = PC_W'(VEC_IRQ_DEF),
   parameter logic [PC_W-1:0]   VEC_XADR = PC_W'(VEC_XADR_DEF)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_IRQ-1:0]   irq_in,
   input  logic [NUM_IRQ-1:0]   irq_mask,
   input  logic                 instr_valid,
   input  logic                 xadr,
   input  logic                 eret,
   input  logic [PC_W-1:0]      pc_cur,
   output logic                 trap_valid,
   output logic [PC_W-1:0]      trap_pc,
   input  logic                 trap_ack,
   output logic [PC_W-1:0]      epc,
   output logic                 epc_we,
   output logic [CAUSE_W-1:0]   cause,
   output logic                 kmode,
   output logic [NUM_IRQ-1:0]   pending,
   output logic                 fault
);

   trap_state_e          r_state;
   trap_state_e          w_state_nxt;
   logic [NUM_IRQ-1:0]   r_irq_prev;
   logic [NUM_IRQ-1:0]   r_pending;
   logic [PC_W-1:0]      r_epc;
   logic [PC_W-1:0]      r_trap_pc;
   logic [CAUSE_W-1:0]   r_cause;
   logic                 r_kmode;

   logic [NUM_IRQ-1:0]   w_irq_src;
   logic [NUM_IRQ-1:0]   w_rise;
   logic [NUM_IRQ-1:0]   w_clr;
   logic                 w_found;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_cap;
   logic [CAUSE_W-1:0]   w_cap_cause;
   logic [PC_W-1:0]      w_cap_epc;
   logic [PC_W-1:0]      w_cap_vec;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
   logic [NUM_IRQ-1:0]   r_sync1;
   logic [NUM_IRQ-1:0]   r_sync2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_src = r_sync2;
`else
   assign w_irq_src = irq_in;
`endif

   assign w_rise = w_irq_src & ~r_irq_prev;

   irq_prio_enc #(.N(NUM_IRQ)) u_prio (
      .i_req   (r_pending & irq_mask),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = '0;
      w_cap       = 1'b0;
      w_cap_cause = '0;
      w_cap_epc   = '0;
      w_cap_vec   = '0;
      case (r_state)
         USER: begin
            if (instr_valid && xadr) begin
               w_state_nxt = ISSUE;
               w_cap       = 1'b1;
               w_cap_cause = CAUSE_XADR;
               w_cap_epc   = pc_cur + PC_W'(4);
               w_cap_vec   = VEC_XADR;
            end else if (instr_valid && w_found) begin
               // The interrupted instruction is replayed, so EPC is its own PC.
               w_state_nxt = ISSUE;
               w_cap       = 1'b1;
               w_cap_cause = {1'b1, w_idx};
               w_cap_epc   = pc_cur;
               w_cap_vec   = VEC_IRQ;
               w_clr       = NUM_IRQ'(1) << w_idx;
            end
         end
         ISSUE: begin
            if (trap_ack) w_state_nxt = KERNEL;
         end
         KERNEL: begin
            if (instr_valid && xadr)      w_state_nxt = FAULT;
            else if (instr_valid && eret) w_state_nxt = USER;
         end
         FAULT: w_state_nxt = FAULT;
         default: w_state_nxt = USER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= USER;
         r_irq_prev <= '0;
         r_pending  <= '0;
         r_epc      <= '0;
         r_trap_pc  <= '0;
         r_cause    <= '0;
         r_kmode    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_irq_prev <= w_irq_src;
         // A new edge on a line wins over the service clear of that line.
         r_pending  <= (r_pending & ~w_clr) | w_rise;
         r_kmode    <= (w_state_nxt == KERNEL) || (w_state_nxt == FAULT);
         if (w_cap) begin
            r_epc     <= w_cap_epc;
            r_trap_pc <= w_cap_vec;
            r_cause   <= w_cap_cause;
         end
      end
   end

   assign trap_valid = (r_state == ISSUE);
   assign trap_pc    = r_trap_pc;
   assign epc        = r_epc;
   assign epc_we     = (r_state == ISSUE) && trap_ack && reset;
   assign cause      = r_cause;
   assign kmode      = r_kmode;
   assign pending    = r_pending;
   assign fault      = (r_state == FAULT);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: hand-computed vectors checked with immediate assertions.
`timescale 1ns/1ps
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_in;
   logic [3:0]  irq_mask;
   logic        instr_valid;
   logic        xadr;
   logic        eret;
   logic [31:0] pc_cur;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic        trap_ack;
   logic [31:0] epc;
   logic        epc_we;
   logic [4:0]  cause;
   logic        kmode;
   logic [3:0]  pending;
   logic        fault;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trap_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
      .instr_valid (instr_valid),
      .xadr        (xadr),
      .eret        (eret),
      .pc_cur      (pc_cur),
      .trap_valid  (trap_valid),
      .trap_pc     (trap_pc),
      .trap_ack    (trap_ack),
      .epc         (epc),
      .epc_we      (epc_we),
      .cause       (cause),
      .kmode       (kmode),
      .pending     (pending),
      .fault       (fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tv"},  32'(trap_valid), 32'd0);
      chk({tag, "_km"},  32'(kmode),      32'd0);
      chk({tag, "_flt"}, 32'(fault),      32'd0);
   endtask

   // ack the outstanding trap, then eret back to USER
   task automatic ack_and_return();
      trap_ack = 1'b1;
      tick();
      trap_ack = 1'b0;
      instr_valid = 1'b1; eret = 1'b1;
      tick();
      instr_valid = 1'b0; eret = 1'b0;
   endtask

   initial begin
      reset = 1'b0; irq_in = '0; irq_mask = 4'hF; instr_valid = 1'b0;
      xadr = 1'b0; eret = 1'b0; pc_cur = '0; trap_ack = 1'b0;
      tick(); tick();
      chk_idle("rst");
      chk("rst_pend",  32'(pending), 32'h0);
      chk("rst_epc",   epc,          32'h0);
      chk("rst_cause", 32'(cause),   32'h0);
      chk("rst_tpc",   trap_pc,      32'h0);
      chk("rst_epcwe", 32'(epc_we),  32'h0);
      reset = 1'b1;
      tick();

      // IRQ line 2: edge register, then ISSUE
      instr_valid = 1'b1; pc_cur = 32'h0040_0010; irq_in = 4'b0100;
      tick();
      chk("irq2_pend", 32'(pending), 32'h4);
      chk("irq2_tv0",  32'(trap_valid), 32'h0);
      tick();
      instr_valid = 1'b0;
      chk("irq2_tv",    32'(trap_valid), 32'h1);
      chk("irq2_tpc",   trap_pc, 32'h8000_0004);
      chk("irq2_cause", 32'(cause), 32'h12);
      chk("irq2_epc",   epc, 32'h0040_0010);
      chk("irq2_pclr",  32'(pending), 32'h0);
      chk("irq2_we0",   32'(epc_we), 32'h0);
      tick(); tick();
      chk("irq2_hold_tv", 32'(trap_valid), 32'h1);
      chk("irq2_hold_c",  32'(cause), 32'h12);
      trap_ack = 1'b1;
      #1;
      chk("irq2_we1", 32'(epc_we), 32'h1);
      tick();
      trap_ack = 1'b0;
      #1;
      chk("irq2_we_off", 32'(epc_we), 32'h0);
      chk("irq2_km",     32'(kmode), 32'h1);
      chk("irq2_tv_off", 32'(trap_valid), 32'h0);

      // IRQ edge while in KERNEL accumulates but is not taken
      irq_in = 4'b0101;
      instr_valid = 1'b1;
      tick();
      chk("kirq_pend", 32'(pending), 32'h1);
      tick();
      chk("kirq_tv", 32'(trap_valid), 32'h0);
      chk("kirq_km", 32'(kmode), 32'h1);
      eret = 1'b1;
      tick();
      eret = 1'b0; instr_valid = 1'b0;
      chk("kirq_ret_km", 32'(kmode), 32'h0);
      chk("kirq_ret_tv", 32'(trap_valid), 32'h0);
      chk("kirq_pend2",  32'(pending), 32'h1);
      instr_valid = 1'b1; pc_cur = 32'h0040_0030;
      tick();
      instr_valid = 1'b0;
      chk("kirq_cause", 32'(cause), 32'h10);
      chk("kirq_epc",   epc, 32'h0040_0030);
      ack_and_return();
      irq_in = 4'b0000;
      tick();

      // illegal instruction
      instr_valid = 1'b1; xadr = 1'b1; pc_cur = 32'h0040_0020;
      tick();
      instr_valid = 1'b0; xadr = 1'b0;
      chk("xadr_tv",    32'(trap_valid), 32'h1);
      chk("xadr_tpc",   trap_pc, 32'h8000_0008);
      chk("xadr_cause", 32'(cause), 32'h0F);
      chk("xadr_epc",   epc, 32'h0040_0024);
      ack_and_return();

      // lines 1 and 3 edge together with xadr: xadr first, then line 1, then line 3
      irq_in = 4'b1010; instr_valid = 1'b1; xadr = 1'b1; pc_cur = 32'h0040_0040;
      tick();
      instr_valid = 1'b0; xadr = 1'b0;
      chk("mix_cause0", 32'(cause), 32'h0F);
      chk("mix_pend0",  32'(pending), 32'hA);
      ack_and_return();
      instr_valid = 1'b1; pc_cur = 32'h0040_0050;
      tick();
      instr_valid = 1'b0;
      chk("mix_cause1", 32'(cause), 32'h11);
      chk("mix_pend1",  32'(pending), 32'h8);
      chk("mix_epc1",   epc, 32'h0040_0050);
      ack_and_return();
      instr_valid = 1'b1; pc_cur = 32'h0040_0060;
      tick();
      instr_valid = 1'b0;
      chk("mix_cause3", 32'(cause), 32'h13);
      chk("mix_pend3",  32'(pending), 32'h0);
      trap_ack = 1'b1;
      tick();
      trap_ack = 1'b0;

      // xadr together with eret in KERNEL -> sticky fault
      instr_valid = 1'b1; xadr = 1'b1; eret = 1'b1;
      tick();
      xadr = 1'b0;
      chk("flt_f",  32'(fault), 32'h1);
      chk("flt_km", 32'(kmode), 32'h1);
      chk("flt_tv", 32'(trap_valid), 32'h0);
      tick();
      eret = 1'b0; instr_valid = 1'b0;
      chk("flt_sticky", 32'(fault), 32'h1);
      irq_in = 4'b0000;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_idle("flt_rst");
      chk("flt_rst_epc",   epc, 32'h0);
      chk("flt_rst_cause", 32'(cause), 32'h0);
      chk("flt_rst_tpc",   trap_pc, 32'h0);

      // masked line 0 stays pending until unmasked
      irq_mask = 4'b1110; irq_in = 4'b0001; instr_valid = 1'b1; pc_cur = 32'h0040_0070;
      tick();
      chk("msk_pend", 32'(pending), 32'h1);
      for (int i = 0; i < 10; i++) tick();
      chk("msk_tv", 32'(trap_valid), 32'h0);
      chk("msk_pend2", 32'(pending), 32'h1);
      irq_mask = 4'hF;
      tick();
      instr_valid = 1'b0;
      chk("msk_tv2",   32'(trap_valid), 32'h1);
      chk("msk_cause", 32'(cause), 32'h10);
      ack_and_return();

      // EPC = PC+4 wraps
      instr_valid = 1'b1; xadr = 1'b1; pc_cur = 32'hFFFF_FFFC;
      tick();
      instr_valid = 1'b0; xadr = 1'b0;
      chk("wrap_epc", epc, 32'h0000_0000);

      // reset during ISSUE with ack asserted: no epc write
      trap_ack = 1'b1; reset = 1'b0;
      #1;
      chk("rsti_we", 32'(epc_we), 32'h0);
      tick();
      trap_ack = 1'b0; reset = 1'b1;
      chk_idle("rsti");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential trap/interrupt controller for the MIPS core. It is the multi-channel, stateful successor to the decoder's single IRQ/XADR handling.
- Latches NUM_IRQ external interrupt lines plus the decoder's illegal-instruction (XADR) flag, applies priority and mask, and tracks kernel mode.
- Captures EPC and cause, then issues a trap redirect to the PC unit with a valid/ack handshake.
- Sits between the control decoder, the PC-select mux, and the register-file write path for $k0 ($26).

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16)
- PC_W, 32, PC/EPC width
- VEC_IRQ, 32'h8000_0004, IRQ handler vector
- VEC_XADR, 32'h8000_0008, illegal-instruction handler vector

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- irq_in  in  NUM_IRQ  level interrupt requests, rising-edge sensitive
- irq_mask  in  NUM_IRQ  1 = line enabled
- instr_valid  in  1  an instruction is at decode this cycle
- xadr  in  1  decoder flags an undefined instruction (qualified by instr_valid)
- eret  in  1  return-from-trap decoded (qualified by instr_valid)
- pc_cur  in  PC_W  PC of the decoding instruction
- trap_valid  out  1  redirect request
- trap_pc  out  PC_W  redirect target
- trap_ack  in  1  PC unit accepted the redirect
- epc  out  PC_W  saved return address, drives $k0 write data
- epc_we  out  1  one-cycle $k0 write strobe
- cause  out  5  {is_irq, line index[3:0]}; XADR = 5'b0_1111
- kmode  out  1  1 = kernel (traps held off)
- pending  out  NUM_IRQ  latched unserviced edges
- fault  out  1  sticky double-fault

Behaviour:
- Reset (reset==0 at a clk edge): state = USER; all outputs 0, including pending, epc, cause, trap_pc, and the irq_in history register.
- Edge detection: pending[i] is set when irq_in[i]==1 and the previous sample was 0. Set beats clear in the same cycle on the same line.
- Eligible IRQ: pending & irq_mask, evaluated only in USER with instr_valid==1. The lowest index wins.
- States:
  - USER:
    - If instr_valid & xadr: go to ISSUE. Cause = 5'h0F, epc = pc_cur+4, trap_pc = VEC_XADR.
    - Else if an eligible IRQ exists: go to ISSUE. Cause = {1, idx}, epc = pc_cur (the instruction is not executed), trap_pc = VEC_IRQ. pending[idx] clears in the same cycle.
    - XADR has priority over IRQ in the same cycle; the IRQ stays pending.
  - ISSUE:
    - trap_valid = 1; trap_pc, epc and cause are held stable.
    - On trap_ack: epc_we pulses for exactly that cycle, kmode goes to 1, next state KERNEL.
    - Without ack, the state holds indefinitely.
  - KERNEL:
    - IRQs are accumulated in pending but not taken.
    - instr_valid & eret: go to USER and clear kmode the next cycle. The PC unit performs the jump to EPC.
    - instr_valid & xadr: go to FAULT.
  - FAULT:
    - fault = 1, trap_valid = 0, kmode = 1.
    - Leaves only on reset.
- Simultaneous eret & xadr in KERNEL: xadr wins (FAULT).
- Masked lines remain pending. A line becomes eligible the cycle its mask bit is set.
- Latency: from the irq_in edge (with eligible decode) to trap_valid is 2 cycles: edge register, then ISSUE.
- Reset mid-ISSUE drops trap_valid on the next edge and does not write epc.
- The PC+4 computation wraps modulo 2^PC_W.

Optional Feature:
- Macro: TRAP_CTRL_IRQ_SYNC_EN.
- When defined: irq_in passes through a 2-flop synchronizer before edge detection. This adds 2 cycles of IRQ latency, and the synchronizer flops reset to 0.
- When undefined: irq_in is sampled directly and is assumed synchronous to clk.

Decomposition:
- Package trap_pkg:
  - state enum {USER, ISSUE, KERNEL, FAULT}
  - CAUSE_XADR = 5'h0F
  - cause field width constant
  - default vector constants
- Sub-module irq_prio_enc: combinational lowest-index-first encoder over NUM_IRQ bits, producing found and idx[3:0].

Test Plan:
- IRQ line 2 edge in USER, mask=4'hF, pc_cur=32'h0040_0010, ack after 3 cycles -> trap_pc=8000_0004, cause=5'h12, epc=0040_0010, epc_we one cycle at ack, kmode=1, pending[2]=0.
- xadr with instr_valid at pc_cur=32'h0040_0020 -> trap_pc=8000_0008, cause=5'h0F, epc=0040_0024.
- Edges on lines 1 and 3 in the same cycle plus xadr -> XADR taken first. After eret, line 1 is taken next, then line 3 on the following return.
- IRQ edge while KERNEL -> pending bit set, no trap_valid. After eret the IRQ is taken on the next instr_valid.
- xadr in KERNEL -> fault=1 sticky; reset=0 for one edge -> all outputs 0, state USER.
- Line 0 masked then edge, then unmask 10 cycles later -> trap on the first instr_valid after unmask, cause=5'h10.
